// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI slave register block.
package qspi_pkg;

  localparam int unsigned CMD_RD_BIT = 7;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned ADDR_W     = 4;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_e;

endpackage

// File: rtl/qspi_sync.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized value.
module qspi_sync #(
  parameter int unsigned     WIDTH   = 1,
  parameter int unsigned     STAGES  = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]             prev_q;

  // Shift the asynchronous input through the chain; keep one extra copy for edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
      prev_q <= chain_q[STAGES-1];
    end
  end

  assign q    = chain_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/qspi_slave.sv
// QSPI slave with a small register file: command byte (read bit + address),
// then one data byte per frame. Define QSPI_SLAVE_BURST_EN to let a frame
// continue with consecutive addresses while CS stays low.
module qspi_slave
  import qspi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned REG_DEPTH   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              CS,
  input  logic              MOSI_0,
  input  logic              MOSI_1,
  input  logic              MOSI_2,
  input  logic              MOSI_3,
  output logic              MISO_0,
  output logic              MISO_1,
  output logic              MISO_2,
  output logic              MISO_3,
  output logic              miso_oe,
  input  logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_data,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  logic                sclk_s, sclk_rise, sclk_fall;
  logic                cs_s, cs_rise, cs_fall;
  logic [NIBBLE_W-1:0] mosi_s, mosi_rise, mosi_fall;
  logic                unused_sync;

  qspi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(reset), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  qspi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(reset), .d(CS), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  qspi_sync #(.WIDTH(NIBBLE_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_mosi (
    .clk(clk), .rst_n(reset), .d({MOSI_3, MOSI_2, MOSI_1, MOSI_0}),
    .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_sync = &{1'b0, sclk_s, cs_rise, cs_fall, mosi_rise, mosi_fall};

  state_e              state_q, state_d;
  logic                nib_q, nib_d;
  logic                rd_q, rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          sh_q, sh_d;
  logic [NIBBLE_W-1:0] miso_q, miso_d;
  logic                oe_q, oe_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          reg_data_q, reg_data_d;
  logic                armed_q, armed_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                flushed;
  logic                byte_done;
  logic                we;
  logic [ADDR_W-1:0]   we_addr;
  logic [7:0]          we_data;
  logic [7:0]          regfile_q [REG_DEPTH];
`ifdef QSPI_SLAVE_BURST_EN
  logic [ADDR_W-1:0]   addr_inc;
`endif

  // Frame sequencing, nibble capture/shift-out and write-request generation.
  always_comb begin
    state_d     = state_q;
    nib_d       = nib_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    sh_d        = sh_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_data_d  = regfile_q[reg_addr];
    // The synchronizer powers up holding CS=1; only trust it once real samples
    // have filled the chain, so a CS held low across reset does not re-arm.
    flushed     = (fill_q == FILL_W'(SYNC_STAGES));
    fill_d      = flushed ? fill_q : fill_q + 1'b1;
    armed_d     = armed_q | (cs_s & flushed);
    byte_done   = 1'b0;
    we          = 1'b0;
    we_addr     = addr_q;
    we_data     = {sh_q[7:4], mosi_s};
`ifdef QSPI_SLAVE_BURST_EN
    addr_inc    = addr_q + 1'b1;
`endif

    if (cs_s) begin
      state_d = IDLE;
      nib_d   = 1'b0;
      miso_d  = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          miso_d = '0;
          oe_d   = 1'b0;
          if (armed_q) begin
            state_d = CMD;
            nib_d   = 1'b0;
          end
        end
        CMD: begin
          if (sclk_fall) begin
            if (!nib_q) begin
              rd_d  = mosi_s[CMD_RD_BIT-NIBBLE_W];
              nib_d = 1'b1;
            end else begin
              addr_d  = mosi_s;
              nib_d   = 1'b0;
              state_d = DATA;
              if (rd_q) begin
                sh_d = regfile_q[mosi_s];
                oe_d = 1'b1;
              end
            end
          end
        end
        DATA: begin
          if (rd_q) begin
            if (sclk_rise) miso_d = nib_q ? sh_q[3:0] : sh_q[7:4];
            if (sclk_fall) begin
              if (!nib_q) nib_d = 1'b1;
              else        byte_done = 1'b1;
            end
          end else if (sclk_fall) begin
            if (!nib_q) begin
              sh_d[7:4] = mosi_s;
              nib_d     = 1'b1;
            end else begin
              we          = 1'b1;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
              wr_data_d   = we_data;
              byte_done   = 1'b1;
            end
          end
          if (byte_done) begin
            nib_d = 1'b0;
`ifdef QSPI_SLAVE_BURST_EN
            addr_d = addr_inc;
            if (rd_q) sh_d = regfile_q[addr_inc];
`else
            state_d = DONE;
            miso_d  = '0;
            oe_d    = 1'b0;
`endif
          end
        end
        DONE: begin
          miso_d = '0;
          oe_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Register FSM state and all outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      nib_q       <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      sh_q        <= '0;
      miso_q      <= '0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      reg_data_q  <= '0;
      armed_q     <= 1'b0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      nib_q       <= nib_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      sh_q        <= sh_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      reg_data_q  <= reg_data_d;
      armed_q     <= armed_d;
      fill_q      <= fill_d;
    end
  end

  // Register file, written once per completed SPI data byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regfile_q <= '{default: '0};
    end else if (we) begin
      regfile_q[we_addr] <= we_data;
    end
  end

  assign {MISO_3, MISO_2, MISO_1, MISO_0} = miso_q;
  assign miso_oe   = oe_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign reg_data  = reg_data_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_slave.sv
// Directed bench for qspi_slave: table of single-byte frames plus hand-written
// abort, burst and mid-frame reset sequences.
module tb_qspi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk;
  logic       CS;
  logic [3:0] mosi;
  logic [3:0] miso;
  logic       miso_oe;
  logic [3:0] reg_addr;
  logic [7:0] reg_data;
  logic       wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int strobe_cnt = 0;
  logic [3:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  qspi_slave #(.SYNC_STAGES(2), .REG_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .CS(CS),
    .MOSI_0(mosi[0]), .MOSI_1(mosi[1]), .MOSI_2(mosi[2]), .MOSI_3(mosi[3]),
    .MISO_0(miso[0]), .MISO_1(miso[1]), .MISO_2(miso[2]), .MISO_3(miso[3]),
    .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_data(reg_data),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      last_wa    <= wr_addr;
      last_wd    <= wr_data;
    end
  end

  typedef struct {
    logic       rd;
    logic [7:0] cmd;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic nib(input logic [3:0] n, output logic [3:0] m, output logic oe);
    mosi = n;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    m  = miso;
    oe = miso_oe;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] b, output logic [7:0] m, output logic [1:0] oe);
    logic [3:0] mh, ml;
    logic       oh, ol;
    nib(b[7:4], mh, oh);
    nib(b[3:0], ml, ol);
    m  = {mh, ml};
    oe = {oh, ol};
  endtask

  task automatic cs_low();
    CS = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    CS = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [7:0] v);
    reg_addr = a;
    repeat (3) @(negedge clk);
    v = reg_data;
  endtask

  initial begin
    logic [7:0] m;
    logic [1:0] oe;
    logic [7:0] v;
    logic [3:0] mn;
    logic       on;
    int         s0;

    tbl[0]  = '{1'b0, 8'h05, 8'hA3, 8'hA3};
    tbl[1]  = '{1'b0, 8'h09, 8'h5C, 8'h5C};
    tbl[2]  = '{1'b0, 8'h7E, 8'h3C, 8'h3C};
    tbl[3]  = '{1'b0, 8'h00, 8'hFF, 8'hFF};
    tbl[4]  = '{1'b0, 8'h02, 8'h77, 8'h77};
    tbl[5]  = '{1'b1, 8'h89, 8'h00, 8'h5C};
    tbl[6]  = '{1'b1, 8'h85, 8'h00, 8'hA3};
    tbl[7]  = '{1'b1, 8'hFE, 8'h00, 8'h3C};
    tbl[8]  = '{1'b0, 8'h05, 8'h12, 8'h12};
    tbl[9]  = '{1'b1, 8'h85, 8'h00, 8'h12};
    tbl[10] = '{1'b1, 8'h80, 8'h00, 8'hFF};

    reset = 1'b0; CS = 1'b1; sclk = 1'b0; mosi = '0; reg_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_miso", miso, 0);
    chk("rst_oe", miso_oe, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reg_data", reg_data, 0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < 11; i++) begin
      s0 = strobe_cnt;
      cs_low();
      chk($sformatf("row%0d_busy_cmd", i), busy, 1);
      xfer(tbl[i].cmd, m, oe);
      chk($sformatf("row%0d_cmd_oe", i), oe, 0);
      xfer(tbl[i].dat, m, oe);
      chk($sformatf("row%0d_done_busy", i), busy, 1);
      if (tbl[i].rd) begin
        chk($sformatf("row%0d_miso", i), m, tbl[i].exp);
        chk($sformatf("row%0d_data_oe", i), oe, 2'b11);
        chk($sformatf("row%0d_rd_nostrobe", i), strobe_cnt, s0);
      end else begin
        chk($sformatf("row%0d_strobe_cnt", i), strobe_cnt, s0 + 1);
        chk($sformatf("row%0d_wr_addr", i), last_wa, tbl[i].cmd[3:0]);
        chk($sformatf("row%0d_wr_data", i), last_wd, tbl[i].exp);
      end
      cs_high();
      chk($sformatf("row%0d_idle_busy", i), busy, 0);
      chk($sformatf("row%0d_idle_oe", i), miso_oe, 0);
      read_reg(tbl[i].cmd[3:0], v);
      chk($sformatf("row%0d_reg_data", i), v, tbl[i].exp);
    end

    // Abort after first data nibble of a write to address 2.
    s0 = strobe_cnt;
    cs_low();
    xfer(8'h02, m, oe);
    nib(4'hB, mn, on);
    cs_high();
    chk("abort_strobe", strobe_cnt, s0);
    chk("abort_busy", busy, 0);
    read_reg(4'h2, v);
    chk("abort_reg2", v, 8'h77);

    // Two-byte write starting at address 15.
    s0 = strobe_cnt;
    cs_low();
    xfer(8'h0F, m, oe);
    xfer(8'h11, m, oe);
    xfer(8'h22, m, oe);
    chk("burst_wr_oe", oe, 0);
    chk("burst_wr_miso", m, 0);
    cs_high();
    read_reg(4'hF, v);
    chk("burst_reg15", v, 8'h11);
`ifdef QSPI_SLAVE_BURST_EN
    chk("burst_strobes", strobe_cnt, s0 + 2);
    read_reg(4'h0, v);
    chk("burst_reg0", v, 8'h22);
`else
    chk("burst_strobes", strobe_cnt, s0 + 1);
    read_reg(4'h0, v);
    chk("burst_reg0", v, 8'hFF);
`endif

    // Two-byte read starting at address 9; address 10 holds zero.
    cs_low();
    xfer(8'h89, m, oe);
    xfer(8'h00, m, oe);
    chk("rdburst_b0", m, 8'h5C);
    xfer(8'h00, m, oe);
    chk("rdburst_b1", m, 8'h00);
`ifdef QSPI_SLAVE_BURST_EN
    chk("rdburst_b1_oe", oe, 2'b11);
`else
    chk("rdburst_b1_oe", oe, 2'b00);
`endif
    cs_high();

    // Reset in the middle of a read frame.
    cs_low();
    xfer(8'h89, m, oe);
    nib(4'h0, mn, on);
    chk("mid_read_nib", mn, 4'h5);
    reset = 1'b0;
    #1;
    chk("midrst_miso", miso, 0);
    chk("midrst_oe", miso_oe, 0);
    chk("midrst_strobe", wr_strobe, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_reg_data", reg_data, 0);
    chk("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    s0 = strobe_cnt;
    repeat (4) @(negedge clk);
    xfer(8'h05, m, oe);
    xfer(8'h99, m, oe);
    chk("postrst_held_busy", busy, 0);
    chk("postrst_held_strobe", strobe_cnt, s0);
    cs_high();
    cs_low();
    xfer(8'h03, m, oe);
    xfer(8'h4D, m, oe);
    chk("postrst_strobe", strobe_cnt, s0 + 1);
    chk("postrst_wr_addr", last_wa, 4'h3);
    cs_high();
    read_reg(4'h3, v);
    chk("postrst_reg3", v, 8'h4D);
    read_reg(4'h9, v);
    chk("postrst_reg9_cleared", v, 8'h00);
    cs_low();
    xfer(8'h83, m, oe);
    xfer(8'h00, m, oe);
    chk("postrst_read", m, 8'h4D);
    chk("postrst_read_oe", oe, 2'b11);
    cs_high();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_slave.md
QSPI_SLAVE -- requirements
Module: qspi_slave

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SYNC_STAGES, 2, synchronizer depth on sclk, CS and MOSI_*
- REG_DEPTH, 16, register-file entries; address width is 4.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, input, 1, single system clock.
- reset, input, 1, asynchronous, active-low.
- sclk, input, 1, QSPI clock from master.
- CS, input, 1, chip select, active-low.
- MOSI_0..MOSI_3, input, 1 each, data nibble from master; MOSI_3 is the MSB.
- MISO_0..MISO_3, output, 1 each, data nibble to master; MISO_3 is the MSB.
- miso_oe, output, 1, MISO drive enable.
- reg_addr, input, 4, local read address.
- reg_data, output, 8, local read data, registered.
- wr_strobe, output, 1, one-cycle pulse per completed SPI write.
- wr_addr, output, 4, address of the completed write, valid with wr_strobe.
- wr_data, output, 8, data of the completed write, valid with wr_strobe.
- busy, output, 1, high whenever state is not IDLE.

Function
REQ-003 sclk, CS and MOSI_* SHALL pass through SYNC_STAGES flops; sclk edges are detected on the synchronized value; clk SHALL be at least 4x sclk.
REQ-004 MOSI SHALL be sampled on the detected sclk falling edge; MISO SHALL be updated on the detected sclk rising edge.
REQ-005 States SHALL be IDLE, CMD, DATA, DONE.
REQ-006 IDLE -> CMD SHALL occur on synchronized CS low.
REQ-007 CMD SHALL capture two nibbles, high nibble first, into cmd[7:0]:
- cmd[7]=1 selects read; cmd[7]=0 selects write.
- cmd[6:4] are ignored.
- cmd[3:0] is the start address.
- After the second nibble: -> DATA.
REQ-008 Write in DATA SHALL capture two nibbles, high first. The regfile is updated and wr_strobe/wr_addr/wr_data are asserted one clk after the second falling edge.
REQ-009 Read on entry to DATA SHALL load regfile[addr] into the shift register. The high nibble drives MISO on the first sclk rise in DATA and the low nibble on the second; miso_oe is 1 throughout DATA-read.
REQ-010 After one data byte without burst: -> DONE; DONE ignores sclk until CS rises.
REQ-011 Synchronized CS high in any state SHALL force IDLE the next clk with MISO=0 and miso_oe=0; a partial byte SHALL be discarded with no wr_strobe and no regfile change.
REQ-012 reg_data SHALL equal regfile[reg_addr] one clk after sampling; on a same-cycle SPI write to that address it returns the old value, and the new value one clk later.
REQ-013 busy SHALL be high whenever state is not IDLE.

Reset
REQ-014 reset low SHALL asynchronously force:
- state=IDLE
- MISO_*=0, miso_oe=0
- wr_strobe=0, wr_addr=0, wr_data=0
- reg_data=0, busy=0
- regfile all zero
- synchronizers to CS=1, sclk=0.
REQ-015 Reset asserted mid-frame SHALL abort the frame without a write; operation resumes only after CS has been seen high and then low again.

Configuration
REQ-016 With QSPI_SLAVE_BURST_EN defined, after each data byte DATA SHALL continue with addr+1 modulo 16 (15 wraps to 0) while CS stays low; a read reloads the shift register from the new address.
REQ-017 Without QSPI_SLAVE_BURST_EN, REQ-010 applies and extra sclk edges produce no writes and keep MISO at 0 with miso_oe=0.

Structure
REQ-018 Package qspi_pkg SHALL hold the state enum, CMD_RD_BIT=7, NIBBLE_W=4 and ADDR_W=4.
REQ-019 Synchronizer plus edge detection SHALL be sub-module qspi_sync, instantiated for sclk, CS and the MOSI bus.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Write cmd 0x05 then data 0xA3 -> one wr_strobe with wr_addr=5, wr_data=0xA3; reg_addr=5 gives reg_data=0xA3.
- Preload addr 9 = 0x5C, send cmd 0x89 -> MISO nibbles 0x5 then 0xC, miso_oe high only during DATA.
- CS raised after the first data nibble of a write to addr 2 -> no wr_strobe, regfile[2] unchanged, state IDLE.
- Burst enabled: write cmd 0x0F then data 0x11, 0x22 -> regfile[15]=0x11, regfile[0]=0x22, two strobes.
- Burst disabled: same stimulus -> only regfile[15]=0x11, one strobe.
- reset pulsed low mid-read -> all outputs zero immediately; the next full frame after a CS cycle completes correctly.
